ksa_sub_pipe: RTL and testbench

//  Pipelined Kogge-Stone subtractor: o_diff = i_a - i_b - i_bin, plus borrow-out, zero and signed-overflow flags.

---
 rtl/ksa_sub_pipe_if.sv | 26 ++
 rtl/ksa_sub_pipe.sv | 110 +++++++++++
 tb/tb_ksa_sub_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ksa_sub_pipe_if.sv
// rtl/ksa_sub_pipe_if.sv - operand/result handshake bundle for the pipelined KS subtractor
interface ksa_sub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_zero;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_bin, i_ready,
        output o_ready, o_valid, o_diff, o_borrow, o_zero, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_bin, i_ready,
        input  o_ready, o_valid, o_diff, o_borrow, o_zero, o_ovf
    );
endinterface

// File: rtl/ksa_sub_pipe.sv
// rtl/ksa_sub_pipe.sv - pipelined Kogge-Stone subtractor with borrow/zero/overflow flags
// One register after pg, one per prefix level, one after post; the whole pipe stalls as a unit.
module ksa_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ksa_sub_pipe_if.slave sub_io
);
    localparam int LEVELS = $clog2(WIDTH);

    logic             adv;
    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] pg_p;
    logic [WIDTH-1:0] pg_g;
    logic             cin;

    // Index 0 is R0 (after pg); index k is the register after prefix level k-1.
    logic [LEVELS:0][WIDTH-1:0] gen_q, gen_d;
    logic [LEVELS:0][WIDTH-1:0] prp_q, prp_d;
    logic [LEVELS:0][WIDTH-1:0] po_q,  po_d;
    logic [LEVELS:0]            cin_q, cin_d;
    logic [LEVELS:0]            amsb_q, amsb_d;
    logic [LEVELS:0]            bmsb_q, bmsb_d;
    logic [LEVELS:0]            vld_q, vld_d;

    logic [WIDTH-1:0] post_diff;
    logic             post_borrow;
    logic             post_zero;
    logic             post_ovf;

    logic             out_vld_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;
    logic             ovf_q;

    assign adv            = ~out_vld_q | sub_io.i_ready;
    assign sub_io.o_ready = adv;

    // a - b - bin == a + ~b + ~bin; the carry-in is folded into bit 0's generate.
    always_comb begin
        bn      = ~sub_io.i_b;
        cin     = ~sub_io.i_bin;
        pg_p    = sub_io.i_a ^ bn;
        pg_g    = sub_io.i_a & bn;
        pg_g[0] = pg_g[0] | (pg_p[0] & cin);
    end

    assign gen_d[0]  = pg_g;
    assign prp_d[0]  = pg_p;
    assign po_d[0]   = pg_p;
    assign cin_d[0]  = cin;
    assign amsb_d[0] = sub_io.i_a[WIDTH-1];
    assign bmsb_d[0] = sub_io.i_b[WIDTH-1];
    assign vld_d[0]  = sub_io.i_valid;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        // Bits below the span keep their (G,P); ones in the shifted P keep P[i] intact there.
        assign gen_d[k]  = gen_q[k-1] | (prp_q[k-1] & (gen_q[k-1] << D));
        assign prp_d[k]  = prp_q[k-1] & ((prp_q[k-1] << D) | ~({WIDTH{1'b1}} << D));
        assign po_d[k]   = po_q[k-1];
        assign cin_d[k]  = cin_q[k-1];
        assign amsb_d[k] = amsb_q[k-1];
        assign bmsb_d[k] = bmsb_q[k-1];
        assign vld_d[k]  = vld_q[k-1];
    end

    assign post_diff   = po_q[LEVELS] ^ {gen_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
    assign post_borrow = ~gen_q[LEVELS][WIDTH-1];
    assign post_zero   = ~|post_diff;
    assign post_ovf    = (amsb_q[LEVELS] ^ bmsb_q[LEVELS]) & (amsb_q[LEVELS] ^ post_diff[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q     <= '0;
            prp_q     <= '0;
            po_q      <= '0;
            cin_q     <= '0;
            amsb_q    <= '0;
            bmsb_q    <= '0;
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (adv) begin
            gen_q     <= gen_d;
            prp_q     <= prp_d;
            po_q      <= po_d;
            cin_q     <= cin_d;
            amsb_q    <= amsb_d;
            bmsb_q    <= bmsb_d;
            vld_q     <= vld_d;
            out_vld_q <= vld_q[LEVELS];
            diff_q    <= post_diff;
            borrow_q  <= post_borrow;
            zero_q    <= post_zero;
            ovf_q     <= post_ovf;
        end
    end

    assign sub_io.o_valid  = out_vld_q;
    assign sub_io.o_diff   = diff_q;
    assign sub_io.o_borrow = borrow_q;
    assign sub_io.o_zero   = zero_q;
    assign sub_io.o_ovf    = ovf_q;
endmodule

// File: tb/tb_ksa_sub_pipe.sv
// tb/tb_ksa_sub_pipe.sv - randomized scoreboard bench for the pipelined KS subtractor
module tb_ksa_sub_pipe;
    localparam int W = 8;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
        logic       ovf;
        int         issue;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    exp_t sb_q[$];
    logic lat_chk;
    logic dir_on;
    exp_t dir_exp;
    logic stall_prev;
    logic [10:0] held;

    ksa_sub_pipe_if #(.WIDTH(W)) bus_if ();

    ksa_sub_pipe #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sub_io (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference built from plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int   d;
        int   sa;
        int   sb;
        int   sd;
        d        = int'(a) - int'(b) - int'(bin);
        sa       = int'(a) - (a[7] ? 256 : 0);
        sb       = int'(b) - (b[7] ? 256 : 0);
        sd       = sa - sb - int'(bin);
        e.diff   = d[7:0];
        e.borrow = (d < 0);
        e.zero   = (d[7:0] == 8'h00);
        e.ovf    = (sd < -128) || (sd > 127);
        e.issue  = 0;
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic rdy, input logic r);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus_if.i_valid = v;
        bus_if.i_a     = a;
        bus_if.i_b     = b;
        bus_if.i_bin   = bin;
        bus_if.i_ready = rdy;
        #1;
        if (!r) begin
            chk("o_ready", bus_if.o_ready, !bus_if.o_valid || rdy);
            if (stall_prev)
                chk("stall_hold", {bus_if.o_diff, bus_if.o_borrow, bus_if.o_zero, bus_if.o_ovf}, held);
            if (v && bus_if.o_ready) begin
                e       = dir_on ? dir_exp : model(a, b, bin);
                e.issue = cyc;
                sb_q.push_back(e);
            end
            if (bus_if.o_valid && rdy) begin
                if (sb_q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff",   bus_if.o_diff,   e.diff);
                    chk("borrow", bus_if.o_borrow, e.borrow);
                    chk("zero",   bus_if.o_zero,   e.zero);
                    chk("ovf",    bus_if.o_ovf,    e.ovf);
                    if (lat_chk) chk("latency", cyc - e.issue, 5);
                end
            end
            stall_prev = bus_if.o_valid && !rdy;
            held       = {bus_if.o_diff, bus_if.o_borrow, bus_if.o_zero, bus_if.o_ovf};
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end
    endtask

    task automatic issue_dir(input logic [7:0] a, input logic [7:0] b, input logic bin,
                             input logic [7:0] d, input logic bo, input logic z, input logic ov);
        dir_exp.diff   = d;
        dir_exp.borrow = bo;
        dir_exp.zero   = z;
        dir_exp.ovf    = ov;
        dir_exp.issue  = 0;
        dir_on         = 1'b1;
        cycle(1'b1, a, b, bin, 1'b1, 1'b0);
        dir_on         = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++)
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", sb_q.size(), 0);
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom % 8)
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        lat_chk = 1'b0; dir_on = 1'b0; stall_prev = 1'b0; held = '0;
        dir_exp = '{diff: 8'h00, borrow: 1'b0, zero: 1'b0, ovf: 1'b0, issue: 0};
        rst = 1'b1;
        bus_if.i_valid = 1'b0; bus_if.i_a = '0; bus_if.i_b = '0;
        bus_if.i_bin = 1'b0; bus_if.i_ready = 1'b0;

        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b1);
        #1;
        chk("rst_valid",  bus_if.o_valid,  0);
        chk("rst_diff",   bus_if.o_diff,   0);
        chk("rst_borrow", bus_if.o_borrow, 0);
        chk("rst_zero",   bus_if.o_zero,   0);
        chk("rst_ovf",    bus_if.o_ovf,    0);
        chk("rst_ready",  bus_if.o_ready,  1);

        lat_chk = 1'b1;
        issue_dir(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        drain();
        issue_dir(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        issue_dir(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        issue_dir(8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        issue_dir(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        issue_dir(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 20; i++)
            cycle(1'b1, pick8(), pick8(), 1'($urandom), 1'b1, 1'b0);
        drain();

        lat_chk = 1'b0;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, pick8(), pick8(), 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, pick8(), pick8(), 1'($urandom), 1'b0, 1'b0);
        drain();

        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, pick8(), pick8(), 1'($urandom), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_valid", bus_if.o_valid, 0);
        issue_dir(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("flush_done", sb_q.size(), 0);

        lat_chk = 1'b0;
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 3) != 0, pick8(), pick8(), 1'($urandom),
                  $urandom_range(0, 3) != 0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
